iir_decimator: RTL and testbench

- Downstream stage of iir_filter; consumes its dv_out/d_out sample stream (sparse valid strobes, signed fixed point Ndint.Ndfrac).
- Keeps one sample in every Ndec, starting at sample index Nphase.
- Rounds and saturates each kept sample to a narrower output word and buffers it in a small FIFO with a valid/ready output, so a back-pressuring consumer does not stall the filter.
- Reports dropped samples and saturation events through sticky flags.

---
 rtl/iir_decimator.sv | 127 ++++++++++++
 tb/tb_iir_decimator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iir_decimator.sv
// Decimating output stage for iir_filter: keeps one sample per Ndec, rounds and
// saturates it to the narrow output format and queues it behind a valid/ready FIFO.
module iir_decimator #(
  parameter int Ndint  = 3,
  parameter int Ndfrac = 22,
  parameter int Noint  = 1,
  parameter int Nofrac = 14,
  parameter int Ndec   = 8,
  parameter int Nphase = 0,
  parameter int Nfifo  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dv_in,
  input  logic signed [Ndint-1:-Ndfrac]    d_in,
  input  logic                             rdy_out,
  output logic                             dv_out,
  output logic signed [Noint-1:-Nofrac]    d_out,
  output logic                             ovf,
  output logic                             sat
);

  localparam int D  = Ndfrac - Nofrac;
  localparam int Wi = Ndint + Ndfrac;
  localparam int Wo = Noint + Nofrac;
  localparam int Ws = Wi + 1;
  localparam int Wq = Ws - D;
  localparam int PW = (Ndec > 1) ? $clog2(Ndec) : 1;
  localparam int AW = $clog2(Nfifo);

  localparam logic [PW-1:0] KEEP_AT   = PW'(Nphase);
  localparam logic [PW-1:0] PHASE_TOP = PW'(Ndec - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(Nfifo);

  // Output range limits expressed in the wider post-shift width
  localparam logic signed [Wq-1:0] QMAX = {{(Wq-Wo+1){1'b0}}, {(Wo-1){1'b1}}};
  localparam logic signed [Wq-1:0] QMIN = {{(Wq-Wo+1){1'b1}}, {(Wo-1){1'b0}}};

  logic [PW-1:0]          phase;
  logic                   keep;
  logic signed [Wi-1:0]   d_vec;
  logic signed [Ws-1:0]   round_sum;
  logic signed [Wq-1:0]   shifted;
  logic                   clip_hi;
  logic                   clip_lo;
  logic signed [Wo-1:0]   q_next;
  logic                   q_valid;
  logic signed [Wo-1:0]   q_data;

  logic signed [Wo-1:0]   mem [Nfifo];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   full;
  logic                   pop;
  logic                   push_ok;

  assign keep = dv_in && (phase == KEEP_AT);

  // One extra bit of headroom keeps the half-LSB rounding add from wrapping
  assign d_vec     = d_in;
  assign round_sum = Ws'(d_vec) + (Ws'(1) <<< (D - 1));
  assign shifted   = Wq'(round_sum >>> D);
  assign clip_hi   = shifted > QMAX;
  assign clip_lo   = shifted < QMIN;
  assign q_next    = clip_hi ? QMAX[Wo-1:0] :
                     clip_lo ? QMIN[Wo-1:0] :
                               shifted[Wo-1:0];

  assign full    = (count == FULL_CNT);
  assign pop     = dv_out && rdy_out;
  assign push_ok = q_valid && (!full || pop);

  assign dv_out = (count != '0);
  assign d_out  = dv_out ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      q_valid <= 1'b0;
      q_data  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      sat     <= 1'b0;
    end else begin
      if (dv_in) begin
        phase <= (phase == PHASE_TOP) ? '0 : phase + PW'(1);
      end

      q_valid <= keep;
      if (keep) begin
        q_data <= q_next;
      end
      if (keep && (clip_hi || clip_lo)) begin
        sat <= 1'b1;
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A full FIFO with no pop drops the sample but leaves the queue untouched
      if (q_valid && full && !pop) begin
        ovf <= 1'b1;
      end

      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // When full, the write slot equals the head being popped, which is safe
  // because the head is read combinationally before this edge
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= q_data;
    end
  end

endmodule

// File: tb/tb_iir_decimator.sv
// Scoreboard bench for iir_decimator: one instance with Ndec=8, one with Ndec=1,
// expectations queued at stimulus time and popped by per-instance monitors.
module tb_iir_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst8, dv8, rdy8, dvo8, ovf8, sat8;
  logic signed [24:0] din8;
  logic signed [14:0] dout8;

  logic               rst1, dv1, rdy1, dvo1, ovf1, sat1;
  logic signed [24:0] din1;
  logic signed [14:0] dout1;

  iir_decimator #(.Ndec(8)) dut8 (
    .clk(clk), .rst(rst8), .dv_in(dv8), .d_in(din8), .rdy_out(rdy8),
    .dv_out(dvo8), .d_out(dout8), .ovf(ovf8), .sat(sat8)
  );

  iir_decimator #(.Ndec(1)) dut1 (
    .clk(clk), .rst(rst1), .dv_in(dv1), .d_in(din1), .rdy_out(rdy1),
    .dv_out(dvo1), .d_out(dout1), .ovf(ovf1), .sat(sat1)
  );

  int tests = 0;
  int fails = 0;
  int exp8[$];
  int exp1[$];
  int outs8 = 0;
  int outs1 = 0;

  task automatic checkOutput(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One-cycle dv_in strobe on the selected instance (0 = Ndec 8, 1 = Ndec 1)
  task automatic applyStimulus(input bit sel, input int value);
    @(posedge clk); #1;
    if (sel) begin dv1 = 1'b1; din1 = 25'(value); end
    else     begin dv8 = 1'b1; din8 = 25'(value); end
    @(posedge clk); #1;
    if (sel) dv1 = 1'b0;
    else     dv8 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst8 && dvo8 && rdy8) begin
      outs8++;
      if (exp8.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL dut8 unexpected output: got %0d, expected none", dout8);
      end else begin
        checkOutput("dut8 d_out", int'(dout8), exp8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && dvo1 && rdy1) begin
      outs1++;
      if (exp1.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL dut1 unexpected output: got %0d, expected none", dout1);
      end else begin
        checkOutput("dut1 d_out", int'(dout1), exp1.pop_front());
      end
    end
  end

  int rnd_in[4]  = '{128, 127, -128, -129};
  int rnd_exp[4] = '{1, 0, 0, -1};
  int sat_in[3]  = '{4194304, -4194304, -12582912};
  int sat_exp[3] = '{16383, -16384, -16384};

  initial begin
    rst8 = 1'b1; dv8 = 1'b0; din8 = '0; rdy8 = 1'b1;
    rst1 = 1'b1; dv1 = 1'b0; din1 = '0; rdy1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset dv_out8", int'(dvo8), 0);
    checkOutput("reset d_out8", int'(dout8), 0);
    checkOutput("reset ovf8", int'(ovf8), 0);
    checkOutput("reset sat8", int'(sat8), 0);
    checkOutput("reset dv_out1", int'(dvo1), 0);
    checkOutput("reset ovf1", int'(ovf1), 0);
    @(posedge clk); #1;
    rst8 = 1'b0; rst1 = 1'b0;

    // Streaming with decimation by 8
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0) exp8.push_back((i * 65536 + 128) >>> 8);
      applyStimulus(1'b0, i * 65536);
      if (i == 0) begin
        @(negedge clk);
        checkOutput("latency N+1 dv_out", int'(dvo8), 0);
        @(negedge clk);
        checkOutput("latency N+2 dv_out", int'(dvo8), 1);
      end
      repeat (5) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    checkOutput("stream output count", outs8, 3);
    checkOutput("stream leftover", exp8.size(), 0);
    checkOutput("stream ovf", int'(ovf8), 0);
    checkOutput("stream sat", int'(sat8), 0);

    // Mid-operation reset: 3 entries queued, phase counter at 5
    rdy8 = 1'b0;
    for (int i = 0; i < 21; i++) applyStimulus(1'b0, i * 65536 + 4096);
    @(negedge clk);
    checkOutput("pre-reset dv_out8", int'(dvo8), 1);
    @(posedge clk); #1; rst8 = 1'b1;
    @(posedge clk); #1; rst8 = 1'b0;
    @(negedge clk);
    checkOutput("post-reset dv_out8", int'(dvo8), 0);
    checkOutput("post-reset d_out8", int'(dout8), 0);
    rdy8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i % 8 == 0) exp8.push_back((i * 65536 + 768 + 128) >>> 8);
      applyStimulus(1'b0, i * 65536 + 768);
    end
    repeat (5) @(posedge clk);
    checkOutput("post-reset phase leftover", exp8.size(), 0);

    // Rounding, Ndec = 1
    for (int i = 0; i < 4; i++) begin
      exp1.push_back(rnd_exp[i]);
      applyStimulus(1'b1, rnd_in[i]);
    end
    repeat (4) @(posedge clk);
    checkOutput("round leftover", exp1.size(), 0);
    checkOutput("round sat", int'(sat1), 0);

    // Saturation
    for (int i = 0; i < 3; i++) begin
      exp1.push_back(sat_exp[i]);
      applyStimulus(1'b1, sat_in[i]);
      if (i == 0) begin
        @(negedge clk);
        checkOutput("sat set after clip", int'(sat1), 1);
      end
    end
    repeat (4) @(posedge clk);
    checkOutput("sat leftover", exp1.size(), 0);
    checkOutput("sat sticky", int'(sat1), 1);

    // Fill FIFO, then push and pop in the same cycle while full
    rdy1 = 1'b0;
    @(posedge clk); #1; dv1 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din1 = 25'(k * 256);
      exp1.push_back(k);
      @(posedge clk); #1;
    end
    dv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1; dv1 = 1'b1; din1 = 25'(9 * 256);
    exp1.push_back(9);
    @(posedge clk); #1; dv1 = 1'b0; rdy1 = 1'b1;
    @(posedge clk); #1; rdy1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("full push/pop ovf", int'(ovf1), 0);
    @(posedge clk); #1; rdy1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("full push/pop drain dv_out", int'(dvo1), 1);
    end
    @(negedge clk);
    checkOutput("full push/pop empty", int'(dvo1), 0);
    checkOutput("full push/pop leftover", exp1.size(), 0);

    // Backpressure and overflow
    @(posedge clk); #1; rdy1 = 1'b0; dv1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      din1 = 25'(k * 256);
      if (k <= 4) exp1.push_back(k);
      @(posedge clk); #1;
    end
    dv1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("overflow ovf", int'(ovf1), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stalled d_out", int'(dout1), 1);
      checkOutput("stalled dv_out", int'(dvo1), 1);
    end
    @(posedge clk); #1; rdy1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("overflow drain dv_out", int'(dvo1), 1);
    end
    @(negedge clk);
    checkOutput("overflow empty", int'(dvo1), 0);
    checkOutput("overflow leftover", exp1.size(), 0);

    // Reset with entries queued and a sample in the quantiser
    @(posedge clk); #1; rdy1 = 1'b0; dv1 = 1'b1;
    for (int k = 7; k <= 9; k++) begin
      din1 = 25'(k * 256);
      @(posedge clk); #1;
    end
    dv1 = 1'b0;
    applyStimulus(1'b1, 10 * 256);
    rst1 = 1'b1;
    @(posedge clk); #1; rst1 = 1'b0;
    @(negedge clk);
    checkOutput("mid-reset dv_out1", int'(dvo1), 0);
    checkOutput("mid-reset d_out1", int'(dout1), 0);
    checkOutput("mid-reset ovf1", int'(ovf1), 0);
    checkOutput("mid-reset sat1", int'(sat1), 0);
    repeat (2) @(negedge clk);
    checkOutput("in-flight discarded", int'(dvo1), 0);
    rdy1 = 1'b1;
    exp1.push_back(5);
    applyStimulus(1'b1, 5 * 256);
    repeat (4) @(posedge clk);
    checkOutput("post-reset leftover", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
